// File: rtl/regfile_param_pkg.sv
// Shared definitions for the regfile_param slice: FSM state encodings,
// default geometry constants and a depth helper.
// Optional feature macro used by this slice: REGFILE_BYPASS_EN.
package regfile_param_pkg;

  localparam int RF_DATA_W_DEFAULT = 32;
  localparam int RF_ADDR_W_DEFAULT = 5;

  // INIT sweeps the array to zero after reset, RUN is normal operation
  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  // Number of architectural registers for a given address width
  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_init_ctrl.sv
// Post-reset clear sequencer for regfile_param. After reset it walks the
// register addresses 1..N-1, asking the parent to write zero to each one,
// then parks in RUN and raises init_done.
module regfile_init_ctrl
  import regfile_param_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_e         state;
  rf_state_e         state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_next;
  logic              done_next;

  // State, sweep counter and done flag; reset restarts the sweep at address 1
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RF_INIT;
      clr_cnt   <= ADDR_W'(1);
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      clr_cnt   <= clr_cnt_next;
      init_done <= done_next;
    end
  end

  // Next-state logic: one clear per edge in INIT, leave on the last address
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    done_next    = init_done;
    clr_we       = 1'b0;
    case (state)
      RF_INIT: begin
        clr_we       = ~rst;
        clr_cnt_next = clr_cnt + ADDR_W'(1);
        if (clr_cnt == '1) begin
          state_next = RF_RUN;
          done_next  = 1'b1;
        end
      end
      RF_RUN: begin
        state_next = RF_RUN;
      end
      default: begin
        state_next = RF_INIT;
      end
    endcase
  end

  assign clr_addr = clr_cnt;

endmodule

// File: rtl/regfile_param.sv
// Parameterised two-read / one-write general purpose register file with
// separate HI and LO registers. Address 0 always reads as zero. After reset
// the array is swept to zero by regfile_init_ctrl before user writes are
// accepted.
// Optional feature macro: REGFILE_BYPASS_EN enables same-cycle forwarding of
// write data to the read ports.
module regfile_param
  import regfile_param_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W_DEFAULT,
  parameter int ADDR_W = RF_ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              hi_we,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] lo_wdata,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              user_req;
  logic              user_we;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;

  regfile_init_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_init_ctrl (
    .clk       (clk),
    .rst       (rst),
    .init_done (init_done),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // A user write is only meaningful in RUN and never to the zero register
  assign user_req = init_done & we & (waddr != '0);
  assign user_we  = user_req & ~rst;

  // Single array write port: the clear sweep wins over user writes
  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = '0;
    arr_wdata = '0;
    if (clr_we) begin
      arr_we    = 1'b1;
      arr_addr  = clr_addr;
      arr_wdata = '0;
    end else if (user_we) begin
      arr_we    = 1'b1;
      arr_addr  = waddr;
      arr_wdata = wdata;
    end
  end

  // GPR storage has no reset; only the sweep clears it
  always_ff @(posedge clk) begin
    if (arr_we) begin
      mem[arr_addr] <= arr_wdata;
    end
  end

  // HI/LO are written independently of the sweep and cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) begin
        hi_q <= hi_wdata;
      end
      if (lo_we) begin
        lo_q <= lo_wdata;
      end
    end
  end

  // Read port 1: zero register and uninitialised array both read as zero
  always_comb begin
    rdata1 = '0;
    if (init_done && (raddr1 != '0)) begin
      rdata1 = mem[raddr1];
    end
`ifdef REGFILE_BYPASS_EN
    if (user_req && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
`endif
  end

  // Read port 2: identical structure so equal addresses give equal data
  always_comb begin
    rdata2 = '0;
    if (init_done && (raddr2 != '0)) begin
      rdata2 = mem[raddr2];
    end
`ifdef REGFILE_BYPASS_EN
    if (user_req && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
`endif
  end

  // HI/LO read path, optionally forwarding the value being written
  always_comb begin
    hi_rdata = hi_q;
    lo_rdata = lo_q;
`ifdef REGFILE_BYPASS_EN
    if (hi_we) begin
      hi_rdata = hi_wdata;
    end
    if (lo_we) begin
      lo_rdata = lo_wdata;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param with default geometry (32 x 32-bit).
// Vectors are applied on the falling edge and outputs checked before the
// next rising edge.
module tb_regfile_param;

  logic        clk;
  logic        rst;
  logic        init_done;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        hi_we;
  logic [31:0] hi_wdata;
  logic        lo_we;
  logic [31:0] lo_wdata;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hi_we;
    logic [31:0] hi_wdata;
    logic        lo_we;
    logic [31:0] lo_wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] exp_r1;
    logic [31:0] exp_r2;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs [9];

  regfile_param dut (
    .clk       (clk),
    .rst       (rst),
    .init_done (init_done),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .hi_we     (hi_we),
    .hi_wdata  (hi_wdata),
    .lo_we     (lo_we),
    .lo_wdata  (lo_wdata),
    .hi_rdata  (hi_rdata),
    .lo_rdata  (lo_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    we       = v.we;
    waddr    = v.waddr;
    wdata    = v.wdata;
    hi_we    = v.hi_we;
    hi_wdata = v.hi_wdata;
    lo_we    = v.lo_we;
    lo_wdata = v.lo_wdata;
    raddr1   = v.raddr1;
    raddr2   = v.raddr2;
  endtask

  task automatic idleInputs();
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    hi_we    = 1'b0;
    hi_wdata = '0;
    lo_we    = 1'b0;
    lo_wdata = '0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic hw, input logic [31:0] hd,
                              input logic lw, input logic [31:0] ld,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] eh, input logic [31:0] el);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd;
    v.hi_we = hw; v.hi_wdata = hd; v.lo_we = lw; v.lo_wdata = ld;
    v.raddr1 = r1; v.raddr2 = r2;
    v.exp_r1 = e1; v.exp_r2 = e2; v.exp_hi = eh; v.exp_lo = el;
    return v;
  endfunction

  initial begin
    int n;
    vec_t v;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] eh;
    logic [31:0] el;

    tests_run    = 0;
    tests_failed = 0;

    // Expected values are the pre-edge stored contents (non-forwarding view)
    vecs[0] = mk(1, 5'd3,  32'h0000_0003, 0, 0, 0, 0, 5'd3,  5'd9,  32'h0,         32'h0,         32'h77,   32'h0);
    vecs[1] = mk(1, 5'd31, 32'hFFFF_FFFF, 0, 0, 0, 0, 5'd3,  5'd31, 32'h3,         32'h0,         32'h77,   32'h0);
    vecs[2] = mk(1, 5'd1,  32'h1111_1111, 0, 0, 0, 0, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h77,   32'h0);
    vecs[3] = mk(0, 5'd2,  32'h0000_0BAD, 0, 0, 0, 0, 5'd1,  5'd3,  32'h1111_1111, 32'h3,         32'h77,   32'h0);
    vecs[4] = mk(0, 5'd0,  32'h0,         0, 0, 0, 0, 5'd2,  5'd0,  32'h0,         32'h0,         32'h77,   32'h0);
    vecs[5] = mk(1, 5'd3,  32'h3333_3333, 0, 0, 1, 32'h0F0F, 5'd3, 5'd1, 32'h3,     32'h1111_1111, 32'h77,   32'h0);
    vecs[6] = mk(0, 5'd0,  32'h0,         0, 0, 0, 0, 5'd3,  5'd3,  32'h3333_3333, 32'h3333_3333, 32'h77,   32'h0F0F);
    vecs[7] = mk(0, 5'd0,  32'h0,         1, 32'hCAFE, 0, 0, 5'd0, 5'd31, 32'h0,     32'hFFFF_FFFF, 32'h77,   32'h0F0F);
    vecs[8] = mk(0, 5'd0,  32'h0,         0, 0, 0, 0, 5'd31, 5'd1,  32'hFFFF_FFFF, 32'h1111_1111, 32'hCAFE, 32'h0F0F);

    // Reset for one edge, then watch the clear sweep with a GPR write pending
    rst = 1'b1;
    idleInputs();
    raddr1 = 5'd9;
    raddr2 = 5'd31;
    stepCycle();
    rst = 1'b0;
    #1;
    checkOutput("reset_init_done", {31'b0, init_done}, 32'h0);
    checkOutput("reset_rdata1", rdata1, 32'h0);
    checkOutput("reset_rdata2", rdata2, 32'h0);
    checkOutput("reset_hi", hi_rdata, 32'h0);
    checkOutput("reset_lo", lo_rdata, 32'h0);

    we    = 1'b1;
    waddr = 5'd9;
    wdata = 32'hFF;
    for (int i = 1; i <= 31; i++) begin
      if (i == 5) begin
        hi_we    = 1'b1;
        hi_wdata = 32'h77;
      end else begin
        hi_we = 1'b0;
      end
      stepCycle();
      if (i < 31) checkOutput("init_done_low", {31'b0, init_done}, 32'h0);
      else        checkOutput("init_done_rise", {31'b0, init_done}, 32'h1);
    end
    idleInputs();
    #1;
    checkOutput("init_write_dropped", rdata1, 32'h0);
    checkOutput("swept_reg31", rdata2, 32'h0);
    checkOutput("hi_written_in_init", hi_rdata, 32'h77);
    checkOutput("lo_untouched", lo_rdata, 32'h0);

    // Table-driven RUN traffic
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      applyStimulus(v);
      e1 = v.exp_r1;
      e2 = v.exp_r2;
      eh = v.exp_hi;
      el = v.exp_lo;
`ifdef REGFILE_BYPASS_EN
      if (v.we && v.waddr != 5'd0 && v.raddr1 == v.waddr) e1 = v.wdata;
      if (v.we && v.waddr != 5'd0 && v.raddr2 == v.waddr) e2 = v.wdata;
      if (v.hi_we) eh = v.hi_wdata;
      if (v.lo_we) el = v.lo_wdata;
`endif
      #1;
      checkOutput($sformatf("vec%0d_rdata1", i), rdata1, e1);
      checkOutput($sformatf("vec%0d_rdata2", i), rdata2, e2);
      checkOutput($sformatf("vec%0d_hi", i), hi_rdata, eh);
      checkOutput($sformatf("vec%0d_lo", i), lo_rdata, el);
      stepCycle();
    end
    idleInputs();

    // Write to reg 5 with the same address on the read port
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr1 = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("r5_same_cycle", rdata1, 32'hDEAD_BEEF);
`else
    checkOutput("r5_same_cycle", rdata1, 32'h0);
`endif
    stepCycle();
    we = 1'b0;
    #1;
    checkOutput("r5_next_cycle", rdata1, 32'hDEAD_BEEF);

    // Writes to the zero register are discarded
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678; raddr1 = 5'd0;
    #1;
    checkOutput("r0_same_cycle", rdata1, 32'h0);
    stepCycle();
    we = 1'b0;
    #1;
    checkOutput("r0_next_cycle", rdata1, 32'h0);

    // Simultaneous HI and LO writes
    hi_we = 1'b1; hi_wdata = 32'hA5A5_A5A5; lo_we = 1'b1; lo_wdata = 32'h5A5A_5A5A;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("hi_same_cycle", hi_rdata, 32'hA5A5_A5A5);
`else
    checkOutput("hi_same_cycle", hi_rdata, 32'hCAFE);
`endif
    stepCycle();
    idleInputs();
    #1;
    checkOutput("hi_next_cycle", hi_rdata, 32'hA5A5_A5A5);
    checkOutput("lo_next_cycle", lo_rdata, 32'h5A5A_5A5A);

    // Write reg 7, then reset, and reset again three steps into the sweep
    we = 1'b1; waddr = 5'd7; wdata = 32'h11; raddr1 = 5'd7; raddr2 = 5'd5;
    stepCycle();
    idleInputs();
    #1;
    checkOutput("r7_written", rdata1, 32'h11);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) stepCycle();
    rst = 1'b1;
    hi_we = 1'b1; hi_wdata = 32'h99;
    we = 1'b1; waddr = 5'd7; wdata = 32'h22;
    stepCycle();
    rst = 1'b0;
    idleInputs();
    #1;
    checkOutput("rereset_init_done", {31'b0, init_done}, 32'h0);
    checkOutput("rereset_hi_write_dropped", hi_rdata, 32'h0);
    checkOutput("rereset_lo", lo_rdata, 32'h0);
    n = 0;
    while (!init_done && n < 40) begin
      stepCycle();
      n++;
    end
    checkOutput("rereset_sweep_edges", n, 32'd31);
    #1;
    checkOutput("r7_after_sweep", rdata1, 32'h0);
    checkOutput("r5_after_sweep", rdata2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
